// File: rtl/fb_write_arbiter.sv
// Three-requester framebuffer write arbiter: IDLE -> WRITE -> ACK, latched address/data, out-of-range writes dropped.
// Round-robin grant by default; define FB_ARB_FIXED_PRI_EN for fixed priority req[0] > req[1] > req[2].
module fb_write_arbiter #(
  parameter int          ADDR_W   = 19,
  parameter int          DATA_W   = 3,
  parameter int unsigned FB_WORDS = 307200
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            req,
  input  logic [3*ADDR_W-1:0]   req_addr,
  input  logic [3*DATA_W-1:0]   req_data,
  output logic [2:0]            ack,
  input  logic                  fb_ready,
  output logic                  fb_wr_en,
  output logic [ADDR_W-1:0]     fb_wr_addr,
  output logic [DATA_W-1:0]     fb_wr_data,
  output logic                  busy,
  output logic                  err_oob
);

  typedef enum logic [1:0] {IDLE, WRITE, ACK} state_t;

  state_t              state;
  logic [1:0]          winner;
  logic                wr_oob;
  logic [1:0]          sel;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;
  logic                sel_oob;
`ifndef FB_ARB_FIXED_PRI_EN
  logic [1:0]          last_winner;
  int                  idx;
`endif

  always_comb begin
    sel = 2'd0;
`ifdef FB_ARB_FIXED_PRI_EN
    if (req[0])      sel = 2'd0;
    else if (req[1]) sel = 2'd1;
    else if (req[2]) sel = 2'd2;
`else
    idx = 0;
    // Walk the search order backwards so the requester closest to last_winner+1 wins.
    for (int k = 2; k >= 0; k--) begin
      idx = (int'(last_winner) + 1 + k) % 3;
      if (req[idx]) sel = 2'(idx);
    end
`endif
    sel_addr = req_addr[int'(sel)*ADDR_W +: ADDR_W];
    sel_data = req_data[int'(sel)*DATA_W +: DATA_W];
    sel_oob  = 32'(sel_addr) >= FB_WORDS;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      winner      <= 2'd0;
      wr_oob      <= 1'b0;
      ack         <= 3'b000;
      fb_wr_en    <= 1'b0;
      fb_wr_addr  <= '0;
      fb_wr_data  <= '0;
      busy        <= 1'b0;
      err_oob     <= 1'b0;
`ifndef FB_ARB_FIXED_PRI_EN
      last_winner <= 2'd2;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            winner      <= sel;
`ifndef FB_ARB_FIXED_PRI_EN
            last_winner <= sel;
`endif
            fb_wr_addr  <= sel_addr;
            fb_wr_data  <= sel_data;
            wr_oob      <= sel_oob;
            fb_wr_en    <= !sel_oob;
            busy        <= 1'b1;
            state       <= WRITE;
          end
        end
        WRITE: begin
          // Out-of-range writes never strobe the framebuffer, so they complete without fb_ready.
          if (wr_oob || fb_ready) begin
            fb_wr_en <= 1'b0;
            ack      <= 3'b001 << winner;
            if (wr_oob) err_oob <= 1'b1;
            state    <= ACK;
          end
        end
        ACK: begin
          ack   <= 3'b000;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter: per-cycle vector table plus hand-written stall, out-of-range, reset and latch sequences.
module tb_fb_write_arbiter;
  localparam int AW = 19;
  localparam int DW = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       req;
  logic [3*AW-1:0]  req_addr;
  logic [3*DW-1:0]  req_data;
  logic [2:0]       ack;
  logic             fb_ready;
  logic             fb_wr_en;
  logic [AW-1:0]    fb_wr_addr;
  logic [DW-1:0]    fb_wr_data;
  logic             busy;
  logic             err_oob;

  fb_write_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FB_WORDS(307200)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
    .ack(ack), .fb_ready(fb_ready), .fb_wr_en(fb_wr_en), .fb_wr_addr(fb_wr_addr),
    .fb_wr_data(fb_wr_data), .busy(busy), .err_oob(err_oob)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          do_rst;
    logic [2:0]    req;
    logic          rdy;
    logic          en;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [2:0]    ack;
    logic          busy;
    logic          err;
  } vec_t;

  vec_t          vecs[$];
  int            total  = 0;
  int            passed = 0;
  logic [AW-1:0] base_addr[3];
  logic [DW-1:0] base_data[3];
  int            order[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [63:0] outs();
    return 64'({fb_wr_en, fb_wr_addr, fb_wr_data, ack, busy, err_oob});
  endfunction

  function automatic logic [63:0] pack(input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                       input logic [2:0] k, input logic b, input logic e);
    return 64'({en, a, d, k, b, e});
  endfunction

  task automatic add(input logic r, input logic [2:0] q, input logic rdy, input logic en,
                     input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [2:0] k,
                     input logic b, input logic e);
    vec_t v;
    v.do_rst = r; v.req = q; v.rdy = rdy; v.en = en; v.addr = a; v.data = d;
    v.ack = k; v.busy = b; v.err = e;
    vecs.push_back(v);
  endtask

  task automatic set_addrs();
    req_addr = {base_addr[2], base_addr[1], base_addr[0]};
    req_data = {base_data[2], base_data[1], base_data[0]};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int en_cnt;
    base_addr[0] = 19'd100; base_addr[1] = 19'd200; base_addr[2] = 19'd300;
    base_data[0] = 3'd6;    base_data[1] = 3'd5;    base_data[2] = 3'd3;
`ifdef FB_ARB_FIXED_PRI_EN
    order = '{0, 0, 0, 0};
`else
    order = '{0, 1, 2, 0};
`endif

    // Single request: write strobe after one edge, ack after two, idle after three.
    add(1, 3'b001, 1, 1, 19'd100, 3'd6, 3'b000, 1, 0);
    add(0, 3'b000, 1, 0, 19'd100, 3'd6, 3'b001, 1, 0);
    add(0, 3'b000, 1, 0, 19'd100, 3'd6, 3'b000, 0, 0);
    // All three held: one grant every three cycles in arbitration order.
    for (int g = 0; g < 4; g++) begin
      add(g == 0, 3'b111, 1, 1, base_addr[order[g]], base_data[order[g]], 3'b000, 1, 0);
      add(0, 3'b111, 1, 0, base_addr[order[g]], base_data[order[g]], 3'(3'b001 << order[g]), 1, 0);
      add(0, 3'b111, 1, 0, base_addr[order[g]], base_data[order[g]], 3'b000, 0, 0);
    end

    rst = 1'b1; req = 3'b000; fb_ready = 1'b0;
    set_addrs();
    #2;
    chk("reset_state", outs(), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      if (vecs[i].do_rst) do_reset();
      req = vecs[i].req;
      fb_ready = vecs[i].rdy;
      step();
      chk($sformatf("vec%0d", i), outs(),
          pack(vecs[i].en, vecs[i].addr, vecs[i].data, vecs[i].ack, vecs[i].busy, vecs[i].err));
    end

    // Stall: fb_ready low for ten cycles holds the strobe and latched values.
    do_reset();
    req = 3'b010; fb_ready = 1'b0;
    en_cnt = 0;
    step();
    req = 3'b000;
    if (fb_wr_en) en_cnt++;
    chk("stall_grant", outs(), pack(1, 19'd200, 3'd5, 3'b000, 1, 0));
    for (int c = 0; c < 10; c++) begin
      step();
      if (fb_wr_en) en_cnt++;
      chk($sformatf("stall_hold%0d", c), outs(), pack(1, 19'd200, 3'd5, 3'b000, 1, 0));
    end
    fb_ready = 1'b1;
    step();
    chk("stall_ack", outs(), pack(0, 19'd200, 3'd5, 3'b010, 1, 0));
    step();
    chk("stall_done", outs(), pack(0, 19'd200, 3'd5, 3'b000, 0, 0));
    chk("stall_en_cycles", 64'(en_cnt), 64'd11);

    // Out-of-range address: no strobe, ack regardless of fb_ready, sticky error.
    do_reset();
    base_addr[2] = 19'd307200; set_addrs();
    req = 3'b100; fb_ready = 1'b0;
    step();
    req = 3'b000;
    chk("oob_write", outs(), pack(0, 19'd307200, 3'd3, 3'b000, 1, 0));
    step();
    chk("oob_ack", outs(), pack(0, 19'd307200, 3'd3, 3'b100, 1, 1));
    step();
    chk("oob_idle", outs(), pack(0, 19'd307200, 3'd3, 3'b000, 0, 1));
    repeat (3) step();
    chk("oob_sticky", outs(), pack(0, 19'd307200, 3'd3, 3'b000, 0, 1));
    // Last valid address is written normally; error stays set.
    base_addr[2] = 19'd307199; set_addrs();
    req = 3'b100; fb_ready = 1'b1;
    step();
    req = 3'b000;
    chk("edge_addr_write", outs(), pack(1, 19'd307199, 3'd3, 3'b000, 1, 1));
    step();
    chk("edge_addr_ack", outs(), pack(0, 19'd307199, 3'd3, 3'b100, 1, 1));
    step();
    base_addr[2] = 19'd300; set_addrs();

    // Reset in the middle of a stalled write aborts it and restarts arbitration at requester 0.
    do_reset();
    req = 3'b111; fb_ready = 1'b1;
    repeat (3) step();
    fb_ready = 1'b0;
    step();
    chk("midrst_pre", outs(), pack(1, 19'd200, 3'd5, 3'b000, 1, 0));
    step();
    #2 rst = 1'b1;
    #1 chk("midrst_abort", outs(), 64'd0);
    @(negedge clk);
    rst = 1'b0; fb_ready = 1'b1;
    step();
    chk("midrst_regrant", outs(), pack(1, 19'd100, 3'd6, 3'b000, 1, 0));
    step();
    chk("midrst_ack", outs(), pack(0, 19'd100, 3'd6, 3'b001, 1, 0));

    // Inputs changed after the grant do not disturb the in-flight write.
    do_reset();
    req = 3'b001; fb_ready = 1'b0;
    step();
    req = 3'b000;
    req_addr[AW-1:0] = 19'd999;
    req_data[DW-1:0] = 3'd1;
    step();
    chk("latch_hold", outs(), pack(1, 19'd100, 3'd6, 3'b000, 1, 0));
    fb_ready = 1'b1;
    step();
    chk("latch_ack", outs(), pack(0, 19'd100, 3'd6, 3'b001, 1, 0));
    set_addrs();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fb_write_arbiter.md
FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 19, framebuffer address width.
REQ-002 SHALL have parameter DATA_W, default 3, pixel colour width.
REQ-003 SHALL have parameter FB_WORDS, default 307200 (640x480), count of valid framebuffer addresses.
REQ-004 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req  input  3  per-requester write request, bit i = requester i.
REQ-007 SHALL have port req_addr  input  3*ADDR_W  requester i address at bits [i*ADDR_W +: ADDR_W].
REQ-008 SHALL have port req_data  input  3*DATA_W  requester i pixel at bits [i*DATA_W +: DATA_W].
REQ-009 SHALL have port ack  output  3  one-cycle completion pulse, bit i = requester i.
REQ-010 SHALL have port fb_ready  input  1  framebuffer accepts a write this cycle.
REQ-011 SHALL have port fb_wr_en  output  1  framebuffer write strobe.
REQ-012 SHALL have port fb_wr_addr  output  ADDR_W  framebuffer write address.
REQ-013 SHALL have port fb_wr_data  output  DATA_W  framebuffer write data.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-015 SHALL have port err_oob  output  1  sticky flag, set when an out-of-range address is dropped.

Function
REQ-016 SHALL implement FSM states IDLE, WRITE, ACK; all outputs registered.
REQ-017 IDLE: if req != 0, SHALL select one winner, latch its addr/data into fb_wr_addr/fb_wr_data, record winner index, go to WRITE next cycle; else stay IDLE.
REQ-018 Winner selection SHALL be round-robin: search starts at (last_winner+1) mod 3, wraps 2->0; last_winner updates on every selection.
REQ-019 WRITE with in-range address: fb_wr_en SHALL be 1; on a rising edge with fb_ready=1 the write is consumed, fb_wr_en->0, ack[winner]->1, state->ACK.
REQ-020 WRITE with fb_ready=0: SHALL hold fb_wr_en=1 and fb_wr_addr/fb_wr_data stable indefinitely.
REQ-021 Address >= FB_WORDS: fb_wr_en SHALL stay 0; SHALL go WRITE->ACK unconditionally with ack[winner]=1 and set err_oob.
REQ-022 ACK: exactly one ack bit high for exactly one cycle; no selection in ACK; next state IDLE.
REQ-023 Minimum issue interval SHALL be 3 cycles (IDLE->WRITE->ACK) when fb_ready held high.
REQ-024 Deassertion of req or change of req_addr/req_data during WRITE/ACK SHALL NOT affect the in-flight write (latched values used).
REQ-025 Requesters not granted SHALL see ack=0 and may hold req indefinitely; round-robin guarantees service within 3 grants.

Reset
REQ-026 On rst: state IDLE, fb_wr_en=0, ack=0, fb_wr_addr=0, fb_wr_data=0, busy=0, err_oob=0, last_winner=2 (requester 0 wins first).
REQ-027 rst asserted mid-WRITE SHALL abort the write with no ack, no fb_wr_en pulse afterwards.
REQ-028 err_oob SHALL clear only on rst.

Configuration
REQ-029 With FB_ARB_FIXED_PRI_EN defined, selection SHALL be fixed priority req[0] > req[1] > req[2] and last_winner SHALL be unused.
REQ-030 Without FB_ARB_FIXED_PRI_EN, selection SHALL be round-robin per REQ-018.

Verification
REQ-031 Reset, req=3'b001, addr0=100, data0=3'd6, fb_ready=1 -> fb_wr_en=1 with addr 100/data 6 in cycle 2, ack=3'b001 in cycle 3, busy low in cycle 4.
REQ-032 req=3'b111 held, fb_ready=1 -> ack sequence 001,010,100,001 every 3 cycles (round-robin); with FB_ARB_FIXED_PRI_EN -> 001 repeated.
REQ-033 req=3'b010, fb_ready=0 for 10 cycles then 1 -> fb_wr_en high 10+1 cycles, addr/data stable, single ack=3'b010 after fb_ready rises.
REQ-034 req=3'b100, addr2=307200 -> fb_wr_en never 1, ack=3'b100 one cycle, err_oob=1 and remains 1 until rst.
REQ-035 rst pulsed while in WRITE with fb_ready=0 -> fb_wr_en=0, ack=0 immediately; next grant goes to requester 0 if req=3'b111.
REQ-036 Requester 0 drops req and changes addr during WRITE -> write still issued with originally latched addr/data and ack[0] pulses.
